// File: rtl/execute_stage_ext_if.sv
// execute_stage_ext_if: E-stage inputs and M-stage / hazard outputs of the
// execute stage, bundled as one bus.
//   slave  : the execute stage itself
//   master : the surrounding pipeline (ID/EX register, hazard unit, MEM stage)
interface execute_stage_ext_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              ValidE;
    logic              FlushE;
    logic              RegWriteE;
    logic              MemWriteE;
    logic              ResultSrcE;
    logic              ALUSrcE;
    logic              BranchE;
    logic [3:0]        ALUControlE;
    logic [2:0]        BranchTypeE;
    logic [XLEN-1:0]   RD1_E;
    logic [XLEN-1:0]   RD2_E;
    logic [XLEN-1:0]   Imm_Ext_E;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [REG_AW-1:0] RD_E;
    logic [1:0]        ForwardAE;
    logic [1:0]        ForwardBE;
    logic [XLEN-1:0]   ResultW;

    logic              StallE;
    logic              PCSrcE;
    logic [XLEN-1:0]   PCTargetE;
    logic              RegWriteM;
    logic              MemWriteM;
    logic              ResultSrcM;
    logic [REG_AW-1:0] RD_M;
    logic [XLEN-1:0]   PCPlus4M;
    logic [XLEN-1:0]   WriteDataM;
    logic [XLEN-1:0]   ALU_ResultM;

    modport slave (
        input  ValidE, FlushE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE,
               ALUControlE, BranchTypeE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
               RD_E, ForwardAE, ForwardBE, ResultW,
        output StallE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );

    modport master (
        output ValidE, FlushE, RegWriteE, MemWriteE, ResultSrcE, ALUSrcE, BranchE,
               ALUControlE, BranchTypeE, RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E,
               RD_E, ForwardAE, ForwardBE, ResultW,
        input  StallE, PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM,
               RD_M, PCPlus4M, WriteDataM, ALU_ResultM
    );
endinterface

// File: rtl/execute_stage_ext.sv
// execute_stage_ext: RV32I-style execute stage with forwarding, full branch
// compare set and EX/MEM pipeline register.
// Build option EXEC_MUL_EN: adds a shift-add multiplier (one bit per cycle)
// that stalls the front end while busy. Without it, ALU code 1010 yields 0.
//
// state | meaning
// IDLE  | no multiply in flight; a mul in EX starts one and stalls
// BUSY  | one shift-add step per cycle, stall held
// DONE  | product ready, stall released, EX/MEM captures it
module execute_stage_ext #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input logic               clk,
    input logic               rst,
    execute_stage_ext_if.slave bus
);
    localparam int         SHW    = $clog2(XLEN);
    localparam logic [3:0] OP_MUL = 4'b1010;

    logic [XLEN-1:0]   src_a, src_b, write_data, alu_res, ex_result;
    logic              cond, stall;
    logic [SHW-1:0]    shamt;

    logic              regwrite_m_q, memwrite_m_q, resultsrc_m_q;
    logic [REG_AW-1:0] rd_m_q;
    logic [XLEN-1:0]   pcplus4_m_q, writedata_m_q, alu_result_m_q;

    // operand forwarding; 11 falls back to the register file value
    always_comb begin
        src_a = bus.RD1_E;
        unique case (bus.ForwardAE)
            2'b01:   src_a = bus.ResultW;
            2'b10:   src_a = alu_result_m_q;
            default: src_a = bus.RD1_E;
        endcase
        write_data = bus.RD2_E;
        unique case (bus.ForwardBE)
            2'b01:   write_data = bus.ResultW;
            2'b10:   write_data = alu_result_m_q;
            default: write_data = bus.RD2_E;
        endcase
        src_b = bus.ALUSrcE ? bus.Imm_Ext_E : write_data;
    end

    assign shamt = src_b[SHW-1:0];

    // single-cycle ALU; mul is not computed here, the multiplier supplies it
    always_comb begin
        alu_res = '0;
        case (bus.ALUControlE)
            4'b0000: alu_res = src_a + src_b;
            4'b0001: alu_res = src_a - src_b;
            4'b0010: alu_res = src_a & src_b;
            4'b0011: alu_res = src_a | src_b;
            4'b0100: alu_res = src_a ^ src_b;
            4'b0101: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            4'b0110: alu_res = {{(XLEN-1){1'b0}}, (src_a < src_b)};
            4'b0111: alu_res = src_a << shamt;
            4'b1000: alu_res = src_a >> shamt;
            4'b1001: alu_res = $unsigned($signed(src_a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

    // branch compare uses the forwarded register B, never the immediate
    always_comb begin
        cond = 1'b0;
        case (bus.BranchTypeE)
            3'b000:  cond = (src_a == write_data);
            3'b001:  cond = (src_a != write_data);
            3'b100:  cond = ($signed(src_a) <  $signed(write_data));
            3'b101:  cond = ($signed(src_a) >= $signed(write_data));
            3'b110:  cond = (src_a <  write_data);
            3'b111:  cond = (src_a >= write_data);
            default: cond = 1'b0;
        endcase
    end

    assign bus.PCTargetE = bus.PCE + bus.Imm_Ext_E;
    assign bus.PCSrcE    = bus.ValidE & bus.BranchE & cond & ~bus.FlushE & ~rst;

`ifdef EXEC_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} mul_state_e;
    localparam logic [SHW-1:0] CNT_LAST = SHW'(XLEN - 1);

    mul_state_e      state_q, state_d;
    logic [XLEN-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
    logic [SHW-1:0]  cnt_q, cnt_d;
    logic            mul_start;

    assign mul_start = bus.ValidE & (bus.ALUControlE == OP_MUL) & ~bus.FlushE;

    // multiplier next-state, shift-add step and stall generation
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        stall    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mul_start) begin
                    mcand_d  = src_a;
                    mplier_d = src_b;
                    acc_d    = '0;
                    cnt_d    = '0;
                    stall    = 1'b1;
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                stall    = 1'b1;
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        // a flush kills the multiply; IDLE never starts on a flushed mul
        if (bus.FlushE) state_d = S_IDLE;
        if (rst) stall = 1'b0;
    end

    // multiplier state and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ex_result = (state_q == S_DONE) ? acc_q : alu_res;
`else
    assign stall     = 1'b0;
    assign ex_result = alu_res;
`endif

    assign bus.StallE = stall;

    // EX/MEM register: reset, then bubble on flush/invalid/stall, else load
    always_ff @(posedge clk) begin
        if (rst || bus.FlushE || !bus.ValidE || stall) begin
            regwrite_m_q   <= 1'b0;
            memwrite_m_q   <= 1'b0;
            resultsrc_m_q  <= 1'b0;
            rd_m_q         <= '0;
            pcplus4_m_q    <= '0;
            writedata_m_q  <= '0;
            alu_result_m_q <= '0;
        end else begin
            regwrite_m_q   <= bus.RegWriteE;
            memwrite_m_q   <= bus.MemWriteE;
            resultsrc_m_q  <= bus.ResultSrcE;
            rd_m_q         <= bus.RD_E;
            pcplus4_m_q    <= bus.PCPlus4E;
            writedata_m_q  <= write_data;
            alu_result_m_q <= ex_result;
        end
    end

    assign bus.RegWriteM   = regwrite_m_q;
    assign bus.MemWriteM   = memwrite_m_q;
    assign bus.ResultSrcM  = resultsrc_m_q;
    assign bus.RD_M        = rd_m_q;
    assign bus.PCPlus4M    = pcplus4_m_q;
    assign bus.WriteDataM  = writedata_m_q;
    assign bus.ALU_ResultM = alu_result_m_q;
endmodule
